btb_upd_sched: RTL and testbench

- Scheduler between branch resolution (EX) and the BTB update port.
- The BTB update path reuses the fetch-side read of the tag/valid/state arrays. A write is therefore only correct in a cycle where the fetch PC indexes the same set as the update PC.
- This block buffers resolved-branch updates in a small FIFO and issues each one only in a set-matching cycle.
- If no match occurs within a bounded wait, it steals one fetch cycle by forcing the fetch PC to the pending branch PC.

---
 rtl/btb_pkg.sv | 19 +
 rtl/btb_upd_fifo.sv | 50 +++++
 rtl/btb_upd_sched.sv | 112 +++++++++++
 tb/tb_btb_upd_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Types and constants shared by the BTB and its update scheduler.
package btb_pkg;

    localparam int SETW = 3;
    localparam int SETS = 1 << SETW;

    typedef struct packed {
        logic [29:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEAL = 2'd2
    } upd_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates with flush and an occupancy counter.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  btb_pkg::upd_entry_t push_data,
    input  logic                pop,
    output btb_pkg::upd_entry_t head,
    output logic                empty,
    output logic                full,
    output logic [CW-1:0]       count
);
    import btb_pkg::upd_entry_t;

    localparam int AW = $clog2(DEPTH);

    upd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & !full & !flush;
    assign pop_ok  = pop & !empty & !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btb_upd_sched.sv
// Holds resolved-branch BTB updates until the fetch PC hits the same set,
// stealing a fetch cycle when the head has waited too long.
module btb_upd_sched #(
    parameter int DEPTH    = 4,
    parameter int SETW     = 3,
    parameter int WAIT_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic                     in_taken,
    input  logic [31:0]              in_target,
    input  logic [31:0]              fetch_pc,
    output logic                     steal_req,
    output logic [31:0]              steal_pc,
    output logic                     update_en,
    output logic [29:0]              update_pc,
    output logic                     actual_taken,
    output logic [31:0]              update_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               dbg_state
);
    import btb_pkg::upd_entry_t, btb_pkg::upd_state_t;
    import btb_pkg::IDLE, btb_pkg::WAIT, btb_pkg::STEAL;

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: an entry transfers on a posedge where in_valid and in_ready
    // are both high and flush is low; in_ready depends only on fullness.
    upd_entry_t head;
    upd_entry_t entry_in;
    upd_state_t state;
    logic [3:0] wait_cnt;
    logic       empty;
    logic       full;
    logic       push_ok;
    logic       match;
    logic       remain;
    logic       unused_bits;

    assign entry_in  = '{pc: in_pc[31:2], taken: in_taken, target: in_target};
    assign push_ok   = in_valid & !full & !flush;
    assign in_ready  = !full;
    assign match     = !empty & (fetch_pc[SETW+1:2] == head.pc[SETW-1:0]);
    assign update_en = match & !flush & !rst;
    assign steal_req = (state == STEAL) & !flush;
    // Whether anything is left after this edge's pop (a same-cycle push counts).
    assign remain    = push_ok | (count > CW'(1));
    assign dbg_state = state;

    assign update_pc     = empty ? '0 : head.pc;
    assign actual_taken  = empty ? 1'b0 : head.taken;
    assign update_target = empty ? '0 : head.target;
    assign steal_pc      = empty ? '0 : {head.pc, 2'b00};

    assign unused_bits = ^{in_pc[1:0], fetch_pc[31:SETW+2], fetch_pc[1:0]};

    btb_upd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_ok),
        .push_data (entry_in),
        .pop       (update_en),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= (update_en && !remain) ? IDLE : WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (update_en) begin
                        state    <= remain ? WAIT : IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'(WAIT_MAX - 1)) begin
                        state    <= STEAL;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                STEAL: begin
                    // Without a match the fetch side ignored the steal; keep asking.
                    if (update_en) begin
                        state    <= remain ? WAIT : IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_upd_sched.sv
// Directed bench for btb_upd_sched: queue-based update model plus literal checks.
module tb_btb_upd_sched;
    localparam int DEPTH    = 4;
    localparam int WAIT_MAX = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_taken;
    logic [31:0] in_target;
    logic [31:0] fetch_pc;
    logic        steal_req;
    logic [31:0] steal_pc;
    logic        update_en;
    logic [29:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
    logic [2:0]  count;
    logic [1:0]  dbg_state;

    logic [31:0] fetch_base;
    logic        honour;
    logic        chk_en;

    int errors;
    int checks;

    // Fetch mux: a stolen cycle fetches the pending branch PC.
    assign fetch_pc = (steal_req && honour) ? steal_pc : fetch_base;

    btb_upd_sched #(.DEPTH(DEPTH), .SETW(3), .WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_taken      (in_taken),
        .in_target     (in_target),
        .fetch_pc      (fetch_pc),
        .steal_req     (steal_req),
        .steal_pc      (steal_pc),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .actual_taken  (actual_taken),
        .update_target (update_target),
        .count         (count),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_taken  = tk;
        in_target = tg;
        step();
        in_valid  = 1'b0;
    endtask

    // Scoreboard: queue of pending updates in issue order.
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t exp_q[$];
    int   run;    // unmatched cycles seen by the current head
    bit   fresh;  // head arrived into an empty queue (spends one extra cycle idle)

    ent_t        m_head;
    logic        m_empty, m_steal, m_match, m_upd, m_push;
    logic [31:0] m_fetch;
    int          thr;

    always @(negedge clk) begin
        if (chk_en) begin
            m_empty = (exp_q.size() == 0);
            m_head  = m_empty ? '{pc: 32'h0, taken: 1'b0, target: 32'h0} : exp_q[0];
            thr     = fresh ? WAIT_MAX + 1 : WAIT_MAX;
            m_steal = !m_empty && (run >= thr) && !flush;
            m_fetch = (m_steal && honour) ? {m_head.pc[31:2], 2'b00} : fetch_base;
            m_match = !m_empty && (m_fetch[4:2] == m_head.pc[4:2]);
            m_upd   = m_match && !flush && !rst;
            m_push  = in_valid && (exp_q.size() < DEPTH);

            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("update_en", 64'(update_en), 64'(m_upd));
            if (!rst) chk("steal_req", 64'(steal_req), 64'(m_steal));
            chk("update_pc", 64'(update_pc), 64'(m_head.pc[31:2]));
            chk("actual_taken", 64'(actual_taken), 64'(m_head.taken));
            chk("update_target", 64'(update_target), 64'(m_head.target));
            chk("steal_pc", 64'(steal_pc), 64'({m_head.pc[31:2], 2'b00}));

            if (rst || flush) begin
                exp_q.delete();
                run   = 0;
                fresh = 1'b0;
            end else begin
                if (m_upd) begin
                    void'(exp_q.pop_front());
                    run   = 0;
                    fresh = 1'b0;
                end else if (!m_empty) begin
                    run++;
                end
                if (m_push) begin
                    exp_q.push_back('{pc: in_pc, taken: in_taken, target: in_target});
                    if (m_empty) begin
                        fresh = 1'b1;
                        run   = 0;
                    end
                end
            end
        end
    end

    bit found;

    initial begin
        errors     = 0;
        checks     = 0;
        chk_en     = 1'b0;
        run        = 0;
        fresh      = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_taken   = 1'b0;
        in_target  = '0;
        fetch_base = '0;
        honour     = 1'b1;

        // Reset for two cycles
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_update_en", 64'(update_en), 64'd0);
        chk("rst_steal_req", 64'(steal_req), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Immediate match: 0x1008 and 0x0108 both index set 2
        fetch_base = 32'h0;
        push(32'h0000_1008, 1'b1, 32'h2000);
        fetch_base = 32'h0000_0108;
        @(negedge clk);
        chk("imm_update_en", 64'(update_en), 64'd1);
        chk("imm_update_pc", 64'(update_pc), 64'h402);
        chk("imm_taken", 64'(actual_taken), 64'd1);
        chk("imm_target", 64'(update_target), 64'h2000);
        chk("imm_count_before", 64'(count), 64'd1);
        step();
        @(negedge clk);
        chk("imm_count_after", 64'(count), 64'd0);

        // Steal: head in set 1, fetch held at set 5
        fetch_base = 32'h14;
        push(32'h1004, 1'b0, 32'h3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("steal_wait_no_update", 64'(update_en), 64'd0);
            chk("steal_wait_no_req", 64'(steal_req), 64'd0);
            step();
        end
        @(negedge clk);
        chk("steal_req", 64'(steal_req), 64'd1);
        chk("steal_pc", 64'(steal_pc), 64'h1004);
        chk("steal_update_en", 64'(update_en), 64'd1);
        step();
        @(negedge clk);
        chk("steal_count_after", 64'(count), 64'd0);

        // Full and back-pressure
        push(32'h104, 1'b1, 32'ha000);
        push(32'h204, 1'b0, 32'ha100);
        push(32'h304, 1'b1, 32'ha200);
        push(32'h404, 1'b0, 32'ha300);
        in_valid  = 1'b1;
        in_pc     = 32'h504;
        in_taken  = 1'b1;
        in_target = 32'ha400;
        step();
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (update_en) found = 1'b1;
            else step();
        end
        chk("full_pop_seen", 64'(found), 64'd1);
        chk("full_ready_at_pop", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        chk("full_ready_after_pop", 64'(in_ready), 64'd1);
        chk("full_count_after_pop", 64'(count), 64'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_fifth_accepted", 64'(count), 64'd4);
        fetch_base = 32'h4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            @(negedge clk);
            if (count == 3'd0) found = 1'b1;
        end
        chk("full_drained", 64'(found), 64'd1);

        // Ordering: A(set 3), B(set 3), C(set 6)
        fetch_base = 32'h0;
        push(32'h10c, 1'b1, 32'hb000);
        push(32'h20c, 1'b0, 32'hb100);
        push(32'h118, 1'b1, 32'hb200);
        fetch_base = 32'hc;
        @(negedge clk);
        chk("order_a_en", 64'(update_en), 64'd1);
        chk("order_a_target", 64'(update_target), 64'hb000);
        step();
        @(negedge clk);
        chk("order_b_en", 64'(update_en), 64'd1);
        chk("order_b_pc", 64'(update_pc), 64'h83);
        chk("order_b_target", 64'(update_target), 64'hb100);
        step();
        fetch_base = 32'h18;
        @(negedge clk);
        chk("order_c_en", 64'(update_en), 64'd1);
        chk("order_c_target", 64'(update_target), 64'hb200);
        step();
        fetch_base = 32'h0;

        // Flush while stuck in STEAL (fetch side ignores the steal)
        honour = 1'b0;
        push(32'h104, 1'b1, 32'hc000);
        push(32'h204, 1'b1, 32'hc100);
        push(32'h304, 1'b1, 32'hc200);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (steal_req) found = 1'b1;
            else step();
        end
        chk("flush_steal_seen", 64'(found), 64'd1);
        step();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h404;
        in_target = 32'hc300;
        @(negedge clk);
        chk("flush_update_en", 64'(update_en), 64'd0);
        chk("flush_steal_req", 64'(steal_req), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_state_idle", 64'(dbg_state), 64'(btb_pkg::IDLE));
        step();
        @(negedge clk);
        chk("flush_push_lost", 64'(count), 64'd0);
        honour = 1'b1;
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
